// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Boot-stream instruction-memory loader. Receives a big-endian
//                byte stream (16-bit word count, then count 32-bit words,
//                MSB first), writes each word into instruction memory starting
//                at 0x00003000 and holds the CPU in reset until the load has
//                completed. Aborts into a sticky error state on an oversized
//                header (or, optionally, a checksum mismatch).
//  Options     : `define IMEM_LOADER_CHECKSUM_EN to append a 32-bit XOR
//                checksum of all written words after the data, verified
//                before the CPU is released.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_loader (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        we,
    output logic [31:0] waddr,
    output logic [31:0] wdata,
    output logic        cpu_reset,
    output logic        done,
    output logic        error,
    output logic [10:0] words_loaded
);

    // Load address of word 0; also the CPU reset vector.
    localparam logic [31:0] c_BASE_ADDR = 32'h0000_3000;
    // Largest accepted word count (4 KiB image).
    localparam logic [15:0] c_MAX_WORDS = 16'd1024;

    // State encoding
    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_HDR0 = 3'd1;
    localparam logic [2:0] c_HDR1 = 3'd2;
    localparam logic [2:0] c_DATA = 3'd3;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [2:0] c_CSUM = 3'd4;
`endif
    localparam logic [2:0] c_DONE = 3'd5;
    localparam logic [2:0] c_ERR  = 3'd6;

    // Where the FSM goes once the payload is complete (or empty).
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [2:0] c_AFTER_DATA = c_CSUM;
`else
    localparam logic [2:0] c_AFTER_DATA = c_DONE;
`endif

    logic [2:0]  r_state;
    logic [7:0]  r_cnt_hi;     // header high byte, held until HDR1 arrives
    logic [10:0] r_total;      // validated word count (<= 1024)
    logic [1:0]  r_byte_cnt;   // byte position inside the current word
    logic [23:0] r_shift;      // first three bytes of the word being built
    logic [10:0] r_words;
    logic        r_we;
    logic [31:0] r_waddr;
    logic [31:0] r_wdata;
    logic        r_cpu_reset;
    logic        r_done;
    logic        r_error;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] r_csum;       // running XOR of every written word
`endif

    logic        w_accept;
    logic [31:0] w_word;
    logic [15:0] w_count;
    logic        w_last_word;
    logic [31:0] w_word_addr;

    // Handshake and datapath helpers; the 4th byte completes w_word directly.
    assign w_accept    = in_valid & in_ready;
    assign w_word      = {r_shift, in_data};
    assign w_count     = {r_cnt_hi, in_data};
    assign w_last_word = ((r_words + 11'd1) == r_total);
    assign w_word_addr = c_BASE_ADDR + {19'd0, r_words, 2'b00};

    // Ready depends on state only so the source never sees a valid->ready path.
    always_comb begin
        in_ready = 1'b0;
        case (r_state)
            c_HDR0,
            c_HDR1,
            c_DATA: in_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            c_CSUM: in_ready = 1'b1;
`endif
            default: in_ready = 1'b0;
        endcase
    end

    // Loader FSM with registered write port and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_cnt_hi    <= 8'd0;
            r_total     <= 11'd0;
            r_byte_cnt  <= 2'd0;
            r_shift     <= 24'd0;
            r_words     <= 11'd0;
            r_we        <= 1'b0;
            r_waddr     <= c_BASE_ADDR;
            r_wdata     <= 32'd0;
            r_cpu_reset <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum      <= 32'd0;
`endif
        end else begin
            // Write strobe is a single-cycle pulse; address/data hold.
            r_we <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    r_state <= c_HDR0;
                end

                c_HDR0: begin
                    if (w_accept) begin
                        r_cnt_hi <= in_data;
                        r_state  <= c_HDR1;
                    end
                end

                c_HDR1: begin
                    if (w_accept) begin
                        r_total <= w_count[10:0];
                        if (w_count > c_MAX_WORDS) begin
                            // Error is flagged on the transition so it is
                            // visible the cycle right after the header.
                            r_state <= c_ERR;
                            r_error <= 1'b1;
                        end else if (w_count == 16'd0) begin
                            r_state <= c_AFTER_DATA;
                        end else begin
                            r_state <= c_DATA;
                        end
                    end
                end

                c_DATA: begin
                    if (w_accept) begin
                        if (r_byte_cnt == 2'd3) begin
                            r_we       <= 1'b1;
                            r_waddr    <= w_word_addr;
                            r_wdata    <= w_word;
                            r_words    <= r_words + 11'd1;
                            r_byte_cnt <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                            r_csum     <= r_csum ^ w_word;
`endif
                            if (w_last_word) begin
                                r_state <= c_AFTER_DATA;
                            end
                        end else begin
                            r_shift    <= {r_shift[15:0], in_data};
                            r_byte_cnt <= r_byte_cnt + 2'd1;
                        end
                    end
                end

`ifdef IMEM_LOADER_CHECKSUM_EN
                c_CSUM: begin
                    if (w_accept) begin
                        if (r_byte_cnt == 2'd3) begin
                            r_byte_cnt <= 2'd0;
                            if (w_word == r_csum) begin
                                r_state <= c_DONE;
                            end else begin
                                r_state <= c_ERR;
                                r_error <= 1'b1;
                            end
                        end else begin
                            r_shift    <= {r_shift[15:0], in_data};
                            r_byte_cnt <= r_byte_cnt + 2'd1;
                        end
                    end
                end
`endif

                c_DONE: begin
                    // One cycle after entry, so release trails the last write.
                    r_done      <= 1'b1;
                    r_cpu_reset <= 1'b0;
                end

                c_ERR: begin
                    r_error     <= 1'b1;
                    r_cpu_reset <= 1'b1;
                end

                default: begin
                    r_state <= c_ERR;
                    r_error <= 1'b1;
                end
            endcase
        end
    end

    assign we           = r_we;
    assign waddr        = r_waddr;
    assign wdata        = r_wdata;
    assign cpu_reset    = r_cpu_reset;
    assign done         = r_done;
    assign error        = r_error;
    assign words_loaded = r_words;

endmodule
`default_nettype wire

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state updates on posedge clk.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-003 SHALL have port: in_valid  input  1  source presents a byte on in_data.
REQ-004 SHALL have port: in_data  input  8  boot stream byte.
REQ-005 SHALL have port: in_ready  output  1  loader accepts a byte; combinational from state only, never from in_valid.
REQ-006 SHALL have port: we  output  1  instruction-memory word write strobe, one cycle per word.
REQ-007 SHALL have port: waddr  output  32  byte address of the written word.
REQ-008 SHALL have port: wdata  output  32  written instruction word.
REQ-009 SHALL have port: cpu_reset  output  1  holds the CPU (PC at 0x00003000) in reset until the load completes.
REQ-010 SHALL have port: done  output  1  load completed successfully; sticky.
REQ-011 SHALL have port: error  output  1  load aborted; sticky.
REQ-012 SHALL have port: words_loaded  output  11  count of words written, 0..1024.

Function
REQ-013 SHALL use states IDLE, HDR0, HDR1, DATA, CSUM, DONE and ERR; CSUM exists only per REQ-030.
REQ-014 SHALL accept a byte only on a posedge with in_valid=1 and in_ready=1; in_ready=1 in HDR0/HDR1/DATA/CSUM, 0 otherwise.
REQ-015 SHALL move IDLE -> HDR0 unconditionally one cycle after reset deasserts.
REQ-016 SHALL take the stream as big-endian: HDR0 byte = count[15:8], HDR1 byte = count[7:0], then count words of 4 bytes each, MSB first.
REQ-017 SHALL, on accepting the HDR1 byte, go to ERR if count > 1024, to DONE if count = 0 (CSUM when enabled), else to DATA.
REQ-018 SHALL, on accepting the 4th byte of word i, assert we for exactly the next cycle with waddr = 0x00003000 + 4*i and wdata = the assembled word.
REQ-019 SHALL increment words_loaded in the same edge that raises we.
REQ-020 SHALL leave DATA after the last word's 4th byte (to DONE, or CSUM when enabled); the final we pulse still occurs.
REQ-021 SHALL accept back-to-back bytes every cycle with no bubbles; in_valid gaps only stall, with no state change.
REQ-022 SHALL hold we=0 in every cycle not covered by REQ-018; waddr/wdata hold their last values.
REQ-023 SHALL, in DONE, drive done=1 and cpu_reset=0 from the cycle after the final we pulse, and stay there until reset.
REQ-024 SHALL, in ERR, drive error=1 with cpu_reset=1 and in_ready=0, and stay there until reset.

Reset
REQ-025 SHALL, while reset=1, set state=IDLE, we=0, waddr=0x00003000, wdata=0, done=0, error=0, cpu_reset=1, words_loaded=0, byte counter=0, checksum accumulator=0.
REQ-026 SHALL abort any in-progress load on reset mid-stream; the partially assembled word is discarded and no we is issued for it.
REQ-027 SHALL keep in_ready=0 during reset and in IDLE.

Configuration
REQ-028 SHALL provide macro IMEM_LOADER_CHECKSUM_EN.
REQ-029 SHALL, without the macro, go from the last data word (or count=0) directly to DONE.
REQ-030 SHALL, with the macro, XOR every written word into a 32-bit accumulator and then accept 4 checksum bytes in CSUM, MSB first.
REQ-031 SHALL, with the macro, go to DONE on a checksum match and to ERR on a mismatch; all data writes still occur.

Verification
REQ-032 SHALL cover: after reset, stream 00 02 24 01 00 05 AC 01 00 00 -> we at 0x3000/0x24010005, then at 0x3004/0xAC010000; words_loaded=2; done=1; cpu_reset=0.
REQ-033 SHALL cover: header 04 01 (count=1025) -> error=1 one cycle after the HDR1 byte, no we, in_ready=0.
REQ-034 SHALL cover: header 00 00 -> done=1 with no we, or with the macro, CSUM 00 00 00 00 -> done=1.
REQ-035 SHALL cover: in_valid toggled 1/0 each cycle over a 1-word load -> the same single write as with continuous valid, done=1.
REQ-036 SHALL cover: reset after 2 data bytes of word 0, then a full 1-word stream 00 01 12 34 56 78 -> exactly one we, at 0x3000 with 0x12345678.
REQ-037 SHALL cover: with the macro, a 2-word load with a wrong checksum -> both we pulses occur, then error=1 and cpu_reset stays 1.
